uart_rx_frontend: RTL and testbench

Serial receive front end of the UART path. Samples the asynchronous `Rx_i` line with 16x oversampling, deframes 8N1 characters (optionally 8E1), and writes each good byte into the receive FIFO through a one-cycle write strobe. It sits directly upstream of the FIFO write port: `wr_o` and `ena_wr_o` drive the FIFO's `wr_i` and `ena_wr`, and `fl_full_i` comes back from the FIFO's `fl_full`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_frontend.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receive front end and the baud tick generator.
// With UART_RX_PARITY_EN defined, the FSM state set includes the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DIV_DEFAULT = 27;
  localparam int OVS_DEFAULT = 16;
  localparam int OVS_MID     = OVS_DEFAULT / 2 - 1;

  // Sample index that lands in the middle of a bit for a given oversampling ratio.
  function automatic int ovs_mid(input int ovs);
    return ovs / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
// Shared between the receive front end and the transmitter.
module uart_baud_tick #(
  parameter int DIV = uart_pkg::DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// 16x-oversampled UART receiver (8N1) writing good bytes into the RX FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int n   = 8,
  parameter int DIV = DIV_DEFAULT,
  parameter int OVS = OVS_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         Rx_i,
  input  logic         fl_full_i,
  output logic [n-1:0] wr_o,
  output logic         ena_wr_o,
  output logic         fr_err_o,
  output logic         ovf_err_o,
  output logic         busy_o
);

  localparam int SW = $clog2(OVS);
  localparam int BW = (n > 1) ? $clog2(n) : 1;
  localparam logic [SW-1:0] SAMP_MID  = SW'(ovs_mid(OVS));
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

  logic          rx_meta;
  logic          rx_s;
  logic          tick;
  logic          armed;
  logic [SW-1:0] samp_cnt;
  logic [BW-1:0] bit_cnt;
  logic [n-1:0]  shreg;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
`endif
  rx_state_t     state;
  rx_state_t     state_nxt;
  logic          mid_hit;
  logic          samp_done;
  logic          bit_last;
  logic          stop_good;
  logic          ena_nxt;
  logic          fr_nxt;
  logic          ovf_nxt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx_i;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign mid_hit   = tick && (samp_cnt == SAMP_MID);
  assign samp_done = tick && (samp_cnt == SAMP_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
`ifdef UART_RX_PARITY_EN
  assign stop_good = rx_s && !(^{shreg, par_bit});
`else
  assign stop_good = rx_s;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (armed && !rx_s) state_nxt = ST_START;
      ST_START:  if (mid_hit) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (samp_done && bit_last) state_nxt = ST_PARITY;
      ST_PARITY: if (samp_done) state_nxt = ST_STOP;
`else
      ST_DATA:   if (samp_done && bit_last) state_nxt = ST_STOP;
`endif
      ST_STOP:   if (samp_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Exactly one verdict per character, taken on the mid-stop sample.
  always_comb begin
    ena_nxt = 1'b0;
    fr_nxt  = 1'b0;
    ovf_nxt = 1'b0;
    if (state == ST_STOP && samp_done) begin
      if (!stop_good) begin
        fr_nxt = 1'b1;
      end else if (fl_full_i) begin
        ovf_nxt = 1'b1;
      end else begin
        ena_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_o      <= '0;
      ena_wr_o  <= 1'b0;
      fr_err_o  <= 1'b0;
      ovf_err_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      ena_wr_o  <= ena_nxt;
      fr_err_o  <= fr_nxt;
      ovf_err_o <= ovf_nxt;
      busy_o    <= (state_nxt != ST_IDLE);
      if (ena_nxt) wr_o <= shreg;
    end
  end

  // A low stop sample disarms start detection until the line returns high (break handling).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b1;
    end else if (state == ST_IDLE) begin
      samp_cnt <= '0;
      bit_cnt  <= '0;
      if (rx_s) armed <= 1'b1;
    end else if (tick) begin
      if ((state == ST_START && mid_hit) || samp_done) begin
        samp_cnt <= '0;
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end
      if (state == ST_DATA && samp_done) bit_cnt <= bit_cnt + 1'b1;
      if (state == ST_STOP && samp_done) armed <= rx_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == ST_DATA && samp_done) shreg <= {rx_s, shreg[n-1:1]};
`ifdef UART_RX_PARITY_EN
    if (state == ST_PARITY && samp_done) par_bit <= rx_s;
`endif
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend (DIV=4, OVS=16); parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_frontend;

  localparam int N        = 8;
  localparam int DIV      = 4;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = DIV * OVS;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         Rx_i;
  logic         fl_full_i;
  logic [N-1:0] wr_o;
  logic         ena_wr_o;
  logic         fr_err_o;
  logic         ovf_err_o;
  logic         busy_o;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .n   (N),
    .DIV (DIV),
    .OVS (OVS)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .Rx_i      (Rx_i),
    .fl_full_i (fl_full_i),
    .wr_o      (wr_o),
    .ena_wr_o  (ena_wr_o),
    .fr_err_o  (fr_err_o),
    .ovf_err_o (ovf_err_o),
    .busy_o    (busy_o)
  );

  int tests = 0;
  int fails = 0;

  int         ena_cnt = 0;
  int         fr_cnt  = 0;
  int         ovf_cnt = 0;
  logic [7:0] cap [0:15];

  always @(negedge clk) begin
    if (ena_wr_o) begin
      cap[ena_cnt % 16] = wr_o;
      ena_cnt++;
    end
    if (fr_err_o)  fr_cnt++;
    if (ovf_err_o) ovf_cnt++;
  end

  task automatic bit_out(input logic b);
    Rx_i = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop_b);
  endtask

  task automatic test_reset;
    rst_i     = 1'b0;
    Rx_i      = 1'b1;
    fl_full_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (wr_o !== 8'h00)   begin fails++; $display("FAIL reset_wr: got %h, expected 00", wr_o); end
    tests++; if (ena_wr_o !== 1'b0) begin fails++; $display("FAIL reset_ena: got %b, expected 0", ena_wr_o); end
    tests++; if (fr_err_o !== 1'b0) begin fails++; $display("FAIL reset_fr: got %b, expected 0", fr_err_o); end
    tests++; if (ovf_err_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b, expected 0", ovf_err_o); end
    tests++; if (busy_o !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
    rst_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // 0xA5 with start-edge latency check on busy_o.
  task automatic test_basic;
    int e0, f0, o0;
    logic [7:0] d;
    e0 = ena_cnt; f0 = fr_cnt; o0 = ovf_cnt;
    d  = 8'hA5;
    Rx_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL busy_latency_early: got %b, expected 0", busy_o); end
    @(posedge clk);
    #1;
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL busy_latency_3clk: got %b, expected 1", busy_o); end
    repeat (BIT_CLKS - 3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(1'b1);
    repeat (4) @(posedge clk);
    #1;
    tests++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL basic_strobes: got %0d, expected 1", ena_cnt - e0); end
    tests++; if (cap[e0 % 16] !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h, expected a5", cap[e0 % 16]); end
    tests++; if (wr_o !== 8'hA5) begin fails++; $display("FAIL basic_wr_hold: got %h, expected a5", wr_o); end
    tests++; if ((fr_cnt - f0) + (ovf_cnt - o0) !== 0) begin fails++; $display("FAIL basic_errors: got %0d, expected 0", (fr_cnt - f0) + (ovf_cnt - o0)); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b, expected 0", busy_o); end
  endtask

  task automatic test_back_to_back;
    int e0, f0;
    e0 = ena_cnt; f0 = fr_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    bit_out(1'b1);
    tests++; if (ena_cnt - e0 !== 2) begin fails++; $display("FAIL b2b_strobes: got %0d, expected 2", ena_cnt - e0); end
    tests++; if (cap[e0 % 16] !== 8'h3C) begin fails++; $display("FAIL b2b_first: got %h, expected 3c", cap[e0 % 16]); end
    tests++; if (cap[(e0 + 1) % 16] !== 8'hC3) begin fails++; $display("FAIL b2b_second: got %h, expected c3", cap[(e0 + 1) % 16]); end
    tests++; if (fr_cnt - f0 !== 0) begin fails++; $display("FAIL b2b_fr: got %0d, expected 0", fr_cnt - f0); end
  endtask

  task automatic test_overflow;
    int e0, o0;
    e0 = ena_cnt; o0 = ovf_cnt;
    fl_full_i = 1'b1;
    send_frame(8'h55, 1'b1);
    bit_out(1'b1);
    fl_full_i = 1'b0;
    tests++; if (ovf_cnt - o0 !== 1) begin fails++; $display("FAIL ovf_pulses: got %0d, expected 1", ovf_cnt - o0); end
    tests++; if (ena_cnt - e0 !== 0) begin fails++; $display("FAIL ovf_no_write: got %0d, expected 0", ena_cnt - e0); end
    tests++; if (wr_o !== 8'hC3) begin fails++; $display("FAIL ovf_wr_hold: got %h, expected c3", wr_o); end
  endtask

  task automatic test_framing;
    int e0, f0;
    e0 = ena_cnt; f0 = fr_cnt;
    send_frame(8'h81, 1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    tests++; if (fr_cnt - f0 !== 1) begin fails++; $display("FAIL frame_fr: got %0d, expected 1", fr_cnt - f0); end
    tests++; if (ena_cnt - e0 !== 0) begin fails++; $display("FAIL frame_no_write: got %0d, expected 0", ena_cnt - e0); end
    send_frame(8'h7E, 1'b1);
    bit_out(1'b1);
    tests++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL frame_recover_cnt: got %0d, expected 1", ena_cnt - e0); end
    tests++; if (wr_o !== 8'h7E) begin fails++; $display("FAIL frame_recover_data: got %h, expected 7e", wr_o); end
  endtask

  task automatic test_break;
    int e0, f0;
    e0 = ena_cnt; f0 = fr_cnt;
    Rx_i = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1;
    bit_out(1'b1);
    bit_out(1'b1);
    tests++; if (fr_cnt - f0 !== 1) begin fails++; $display("FAIL break_fr: got %0d, expected 1", fr_cnt - f0); end
    tests++; if (ena_cnt - e0 !== 0) begin fails++; $display("FAIL break_no_write: got %0d, expected 0", ena_cnt - e0); end
    send_frame(8'h5A, 1'b1);
    bit_out(1'b1);
    tests++; if (wr_o !== 8'h5A) begin fails++; $display("FAIL break_recover: got %h, expected 5a", wr_o); end
  endtask

  task automatic test_false_start;
    int e0, f0, o0;
    e0 = ena_cnt; f0 = fr_cnt; o0 = ovf_cnt;
    Rx_i = 1'b0;
    repeat (6 * DIV) @(posedge clk);
    #1;
    Rx_i = 1'b1;
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL glitch_busy_high: got %b, expected 1", busy_o); end
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL glitch_busy_low: got %b, expected 0", busy_o); end
    tests++; if ((ena_cnt - e0) + (fr_cnt - f0) + (ovf_cnt - o0) !== 0) begin
      fails++; $display("FAIL glitch_pulses: got %0d, expected 0", (ena_cnt - e0) + (fr_cnt - f0) + (ovf_cnt - o0));
    end
  endtask

  task automatic test_reset_midframe;
    int e0, f0, o0;
    e0 = ena_cnt; f0 = fr_cnt; o0 = ovf_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    rst_i = 1'b0;
    #2;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b, expected 0", busy_o); end
    tests++; if (wr_o !== 8'h00) begin fails++; $display("FAIL midrst_wr: got %h, expected 00", wr_o); end
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    Rx_i  = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
    tests++; if ((ena_cnt - e0) + (fr_cnt - f0) + (ovf_cnt - o0) !== 0) begin
      fails++; $display("FAIL midrst_pulses: got %0d, expected 0", (ena_cnt - e0) + (fr_cnt - f0) + (ovf_cnt - o0));
    end
    send_frame(8'h12, 1'b1);
    bit_out(1'b1);
    tests++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL midrst_next_cnt: got %0d, expected 1", ena_cnt - e0); end
    tests++; if (wr_o !== 8'h12) begin fails++; $display("FAIL midrst_next_data: got %h, expected 12", wr_o); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic pb);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(pb);
    bit_out(1'b1);
  endtask

  task automatic test_parity;
    int e0, f0;
    e0 = ena_cnt; f0 = fr_cnt;
    send_frame_par(8'h07, 1'b1);
    bit_out(1'b1);
    tests++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL par_good_cnt: got %0d, expected 1", ena_cnt - e0); end
    tests++; if (wr_o !== 8'h07) begin fails++; $display("FAIL par_good_data: got %h, expected 07", wr_o); end
    send_frame_par(8'h07, 1'b0);
    bit_out(1'b1);
    tests++; if (fr_cnt - f0 !== 1) begin fails++; $display("FAIL par_bad_fr: got %0d, expected 1", fr_cnt - f0); end
    tests++; if (ena_cnt - e0 !== 1) begin fails++; $display("FAIL par_bad_no_write: got %0d, expected 1", ena_cnt - e0); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_overflow;
    test_framing;
    test_break;
    test_false_start;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
